// File: rtl/r5fp_int_to_float_if.sv
// Operand/result bundle for the integer-to-float converter.
// The master drives the operand side and the slave (the converter) drives the result side.
interface r5fp_int_to_float_if #(
    parameter int INT_W = 64,
    parameter int SIG_W = 23,
    parameter int EXP_W = 8
);
    // Handshake: valid_i qualifies a_i/is_signed/rnd_i in the same cycle and there is no
    // ready; valid_o pulses for exactly one cycle per accepted operand, and z_o/nx_o hold
    // their last value while valid_o is low.
    logic                   valid_i;
    logic [INT_W-1:0]       a_i;
    logic                   is_signed;
    logic [2:0]             rnd_i;
    logic                   valid_o;
    logic [SIG_W+EXP_W:0]   z_o;
    logic                   nx_o;

    modport master (
        output valid_i, a_i, is_signed, rnd_i,
        input  valid_o, z_o, nx_o
    );

    modport slave (
        input  valid_i, a_i, is_signed, rnd_i,
        output valid_o, z_o, nx_o
    );
endinterface

// File: rtl/r5fp_int_to_float.sv
// Single-cycle integer to IEEE-754 conversion: the LZC, normalising shift and rounding
// are combinational, followed by one output register.
module r5fp_int_to_float #(
    parameter int INT_W = 64,
    parameter int SIG_W = 23,
    parameter int EXP_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    r5fp_int_to_float_if.slave   fp_if
);
    localparam int LZ_W = $clog2(INT_W);
    localparam int GPOS = INT_W - 2 - SIG_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(INT_W - 1 + BIAS);

    logic                 sign_d;
    logic [INT_W-1:0]     mag;
    logic [INT_W-1:0]     norm;
    logic [LZ_W-1:0]      lzc;
    logic [SIG_W-1:0]     frac;
    logic                 guard;
    logic                 sticky;
    logic                 inc;
    logic [SIG_W:0]       frac_rnd;
    logic [EXP_W-1:0]     exp_d;
    logic [SIG_W+EXP_W:0] z_d, z_q;
    logic                 nx_d, nx_q;
    logic                 valid_q;

    always_comb begin
        sign_d = fp_if.is_signed & fp_if.a_i[INT_W-1];
        // Negating -2^(INT_W-1) wraps to itself, which is the correct unsigned magnitude.
        mag = sign_d ? (~fp_if.a_i + INT_W'(1)) : fp_if.a_i;

        lzc = '0;
        for (int i = 0; i < INT_W; i++) begin
            if (mag[i]) lzc = LZ_W'(INT_W - 1 - i);
        end

        norm   = mag << lzc;
        frac   = norm[INT_W-2 -: SIG_W];
        guard  = norm[GPOS];
        sticky = |norm[GPOS-1:0];

        case (fp_if.rnd_i)
            3'b001:  inc = 1'b0;
            3'b010:  inc = (guard | sticky) & sign_d;
            3'b011:  inc = (guard | sticky) & ~sign_d;
            3'b100:  inc = guard;
            default: inc = guard & (sticky | frac[0]);
        endcase

        // A carry out of the fraction leaves it all zeros and bumps the exponent.
        frac_rnd = {1'b0, frac} + (SIG_W + 1)'(inc);
        exp_d    = EXP_TOP - EXP_W'(lzc) + EXP_W'(frac_rnd[SIG_W]);

        // The implicit-one position is clear only when the magnitude is zero.
        if (norm[INT_W-1]) begin
            z_d  = {sign_d, exp_d, frac_rnd[SIG_W-1:0]};
            nx_d = guard | sticky;
        end else begin
            z_d  = '0;
            nx_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            z_q     <= '0;
            nx_q    <= 1'b0;
        end else begin
            valid_q <= fp_if.valid_i;
            if (fp_if.valid_i) begin
                z_q  <= z_d;
                nx_q <= nx_d;
            end
        end
    end

    assign fp_if.valid_o = valid_q;
    assign fp_if.z_o     = z_q;
    assign fp_if.nx_o    = nx_q;
endmodule

// File: tb/tb_r5fp_int_to_float.sv
// Bench for r5fp_int_to_float: directed binary32 vectors, hold, reset, random stream
// against an arithmetic reference model, and a binary64 instance.
module tb_r5fp_int_to_float;
    logic clk = 1'b0;
    logic reset = 1'b1;

    r5fp_int_to_float_if #(.INT_W(64), .SIG_W(23), .EXP_W(8))  if32();
    r5fp_int_to_float_if #(.INT_W(64), .SIG_W(52), .EXP_W(11)) if64();

    r5fp_int_to_float #(.INT_W(64), .SIG_W(23), .EXP_W(8)) dut32 (
        .clk(clk), .reset(reset), .fp_if(if32.slave)
    );
    r5fp_int_to_float #(.INT_W(64), .SIG_W(52), .EXP_W(11)) dut64 (
        .clk(clk), .reset(reset), .fp_if(if64.slave)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [32:0] exp_q[$];
    logic [32:0] last_out = '0;

    // Reference: value-level rounding of |a| to 24 significant bits, returns {nx, z}.
    function automatic logic [32:0] model(input logic [63:0] a, input logic s, input logic [2:0] r);
        logic        sign, inexact, inc;
        logic [64:0] mag, q, rem, half;
        int          p, sh, e;
        sign = s & a[63];
        mag  = sign ? ((65'd1 << 64) - {1'b0, a}) : {1'b0, a};
        if (mag == 65'd0) return 33'd0;
        p = 0;
        for (int i = 0; i < 65; i++) if (mag[i]) p = i;
        if (p <= 23) begin
            q = mag << (23 - p); rem = '0; half = '0;
        end else begin
            sh = p - 23;
            q = mag >> sh;
            rem = mag - (q << sh);
            half = 65'd1 << (sh - 1);
        end
        inexact = (rem != 65'd0);
        case (r)
            3'd1: inc = 1'b0;
            3'd2: inc = inexact & sign;
            3'd3: inc = inexact & ~sign;
            3'd4: inc = inexact && (rem >= half);
            default: inc = inexact && ((rem > half) || (rem == half && q[0]));
        endcase
        q = q + 65'(inc);
        e = p;
        if (q == (65'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        return {inexact, sign, 8'(e + 127), q[22:0]};
    endfunction

    task automatic drive(input logic v, input logic [63:0] a, input logic s, input logic [2:0] r);
        if32.valid_i   = v;
        if32.a_i       = a;
        if32.is_signed = s;
        if32.rnd_i     = r;
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] a;
        case ($urandom_range(0, 15))
            0: a = '0;
            1: a = 64'h8000_0000_0000_0000;
            2: a = '1;
            default: begin
                a = {$urandom, $urandom};
                a = a >> $urandom_range(0, 63);
                if ($urandom_range(0, 2) == 0) a = -a;
            end
        endcase
        return a;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, rand_operand(), 1'(k), 3'd0);
            @(negedge clk);
            chk_cnt++;
            if (if32.valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", if32.valid_o);
            else pass_cnt++;
            chk_cnt++;
            if (if32.z_o !== 32'h0) $display("FAIL reset_z: got %h expected 00000000", if32.z_o);
            else pass_cnt++;
            chk_cnt++;
            if (if32.nx_o !== 1'b0) $display("FAIL reset_nx: got %b expected 0", if32.nx_o);
            else pass_cnt++;
        end
        reset = 1'b0;
    endtask

    typedef struct {
        logic [63:0] a;
        logic        s;
        logic [2:0]  r;
        logic [31:0] z;
        logic        nx;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[22];
        tbl[0]  = '{64'd1, 1'b0, 3'd0, 32'h3F80_0000, 1'b0};
        tbl[1]  = '{'1, 1'b1, 3'd0, 32'hBF80_0000, 1'b0};
        tbl[2]  = '{'1, 1'b0, 3'd0, 32'h5F80_0000, 1'b1};
        tbl[3]  = '{'1, 1'b0, 3'd1, 32'h5F7F_FFFF, 1'b1};
        tbl[4]  = '{'1, 1'b0, 3'd3, 32'h5F80_0000, 1'b1};
        tbl[5]  = '{'1, 1'b0, 3'd2, 32'h5F7F_FFFF, 1'b1};
        tbl[6]  = '{64'h8000_0000_0000_0000, 1'b1, 3'd0, 32'hDF00_0000, 1'b0};
        tbl[7]  = '{64'h8000_0000_0000_0000, 1'b0, 3'd0, 32'h5F00_0000, 1'b0};
        tbl[8]  = '{64'h100_0001, 1'b0, 3'd0, 32'h4B80_0000, 1'b1};
        tbl[9]  = '{64'h100_0001, 1'b0, 3'd1, 32'h4B80_0000, 1'b1};
        tbl[10] = '{64'h100_0001, 1'b0, 3'd2, 32'h4B80_0000, 1'b1};
        tbl[11] = '{64'h100_0001, 1'b0, 3'd3, 32'h4B80_0001, 1'b1};
        tbl[12] = '{64'h100_0001, 1'b0, 3'd4, 32'h4B80_0001, 1'b1};
        tbl[13] = '{64'h100_0001, 1'b0, 3'd6, 32'h4B80_0000, 1'b1};
        tbl[14] = '{-64'sh100_0001, 1'b1, 3'd2, 32'hCB80_0001, 1'b1};
        tbl[15] = '{-64'sh100_0001, 1'b1, 3'd3, 32'hCB80_0000, 1'b1};
        tbl[16] = '{64'hFF_FFFF, 1'b0, 3'd3, 32'h4B7F_FFFF, 1'b0};
        tbl[17] = '{64'd0, 1'b0, 3'd0, 32'h0, 1'b0};
        tbl[18] = '{64'd0, 1'b1, 3'd1, 32'h0, 1'b0};
        tbl[19] = '{64'd0, 1'b1, 3'd2, 32'h0, 1'b0};
        tbl[20] = '{64'd0, 1'b0, 3'd4, 32'h0, 1'b0};
        tbl[21] = '{64'd0, 1'b1, 3'd7, 32'h0, 1'b0};
        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].a, tbl[i].s, tbl[i].r);
            @(negedge clk);
            chk_cnt++;
            if (if32.valid_o !== 1'b1) $display("FAIL dir_valid[%0d]: got %b expected 1", i, if32.valid_o);
            else pass_cnt++;
            chk_cnt++;
            if (if32.z_o !== tbl[i].z) $display("FAIL dir_z[%0d]: got %h expected %h", i, if32.z_o, tbl[i].z);
            else pass_cnt++;
            chk_cnt++;
            if (if32.nx_o !== tbl[i].nx) $display("FAIL dir_nx[%0d]: got %b expected %b", i, if32.nx_o, tbl[i].nx);
            else pass_cnt++;
        end
        last_out = {tbl[21].nx, tbl[21].z};
    endtask

    task automatic test_hold();
        drive(1'b1, 64'd3, 1'b0, 3'd0);
        @(negedge clk);
        last_out = {1'b0, 32'h4040_0000};
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, '1, 1'b0, 3'd0);
            @(negedge clk);
            chk_cnt++;
            if (if32.valid_o !== 1'b0) $display("FAIL hold_valid: got %b expected 0", if32.valid_o);
            else pass_cnt++;
            chk_cnt++;
            if ({if32.nx_o, if32.z_o} !== last_out)
                $display("FAIL hold_out: got %h expected %h", {if32.nx_o, if32.z_o}, last_out);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a;
        logic        s, v;
        logic [2:0]  r;
        logic [32:0] e;
        drive(1'b1, 64'd5, 1'b0, 3'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 64'd7, 1'b0, 3'd0);
        @(negedge clk);
        reset = 1'b0;
        chk_cnt++;
        if (if32.valid_o !== 1'b0 || if32.z_o !== 32'h0)
            $display("FAIL midreset: got valid %b z %h expected valid 0 z 00000000", if32.valid_o, if32.z_o);
        else pass_cnt++;
        last_out = '0;
        for (int k = 0; k < 400; k++) begin
            v = (k < 8) ? 1'b1 : ($urandom_range(0, 9) != 0);
            a = rand_operand();
            s = 1'($urandom_range(0, 1));
            r = 3'($urandom_range(0, 7));
            drive(v, a, s, r);
            if (v) exp_q.push_back(model(a, s, r));
            @(negedge clk);
            chk_cnt++;
            if (if32.valid_o !== v) $display("FAIL b2b_valid[%0d]: got %b expected %b", k, if32.valid_o, v);
            else pass_cnt++;
            if (v && exp_q.size() != 0) last_out = exp_q.pop_front();
            chk_cnt++;
            if ({if32.nx_o, if32.z_o} !== last_out)
                $display("FAIL b2b_out[%0d]: a %h s %b r %0d got %h expected %h",
                         k, a, s, r, {if32.nx_o, if32.z_o}, last_out);
            else pass_cnt++;
        end
        drive(1'b0, '0, 1'b0, 3'd0);
    endtask

    task automatic test_binary64();
        logic [63:0] a_t[3];
        logic        s_t[3];
        logic [63:0] z_t[3];
        a_t = '{64'd1, '1, 64'd0};
        s_t = '{1'b0, 1'b1, 1'b1};
        z_t = '{64'h3FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000, 64'h0};
        for (int k = 0; k < 3; k++) begin
            if64.valid_i   = 1'b1;
            if64.a_i       = a_t[k];
            if64.is_signed = s_t[k];
            if64.rnd_i     = 3'd0;
            @(negedge clk);
            chk_cnt++;
            if (if64.valid_o !== 1'b1 || if64.z_o !== z_t[k] || if64.nx_o !== 1'b0)
                $display("FAIL b64[%0d]: got valid %b z %h nx %b expected valid 1 z %h nx 0",
                         k, if64.valid_o, if64.z_o, if64.nx_o, z_t[k]);
            else pass_cnt++;
        end
        if64.valid_i = 1'b0;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 3'd0);
        if64.valid_i   = 1'b0;
        if64.a_i       = '0;
        if64.is_signed = 1'b0;
        if64.rnd_i     = 3'd0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_binary64();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
